// File: rtl/muxnxn_pkg.sv
// Shared types for the N:1 registered handshake mux.
package muxnxn_pkg;

  // Arbitration mode carried on muxnxn_port_mode.
  typedef enum logic {
    MUXNXN_MODE_MANUAL = 1'b0,
    MUXNXN_MODE_RR     = 1'b1
  } muxnxn_mode_t;

endpackage

// File: rtl/muxnxn_arb_if.sv
// Handshake bundle between N producers, the mux and one consumer.
interface muxnxn_arb_if #(
  parameter int M = 16,
  parameter int N = 4
);
  import muxnxn_pkg::*;
  localparam int SW = $clog2(N);

  muxnxn_mode_t     muxnxn_port_mode;
  logic [SW-1:0]    muxnxn_port_sel;
  logic [N*M-1:0]   muxnxn_port_in_data;
  logic [N-1:0]     muxnxn_port_in_valid;
  logic [N-1:0]     muxnxn_port_in_ready;
  logic [M-1:0]     muxnxn_port_out_data;
  logic [SW-1:0]    muxnxn_port_out_chan;
  logic             muxnxn_port_out_valid;
  logic             muxnxn_port_out_ready;

  // Producer/consumer side (drives requests, accepts output).
  modport master (
    output muxnxn_port_mode, muxnxn_port_sel, muxnxn_port_in_data,
           muxnxn_port_in_valid, muxnxn_port_out_ready,
    input  muxnxn_port_in_ready, muxnxn_port_out_data,
           muxnxn_port_out_chan, muxnxn_port_out_valid
  );

  // Mux side.
  modport slave (
    input  muxnxn_port_mode, muxnxn_port_sel, muxnxn_port_in_data,
           muxnxn_port_in_valid, muxnxn_port_out_ready,
    output muxnxn_port_in_ready, muxnxn_port_out_data,
           muxnxn_port_out_chan, muxnxn_port_out_valid
  );
endinterface

// File: rtl/muxnxn_rr_pick.sv
// Rotating priority encoder: first set req bit searching from ptr+1 upward,
// wrapping modulo N. Purely combinational.
module muxnxn_rr_pick #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);
  logic [SW-1:0] j;

  // Walk the search order backwards so the earliest candidate wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = '0;
    for (int k = N; k >= 1; k--) begin
      j = SW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt_idx = j;
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/muxnxn_arb.sv
// N-input, M-bit registered mux with valid/ready on every port.
// Optional round-robin arbitration is built when MUXNXN_ARB_RR_EN is
// defined; otherwise the block is manual-select only and mode is ignored.
module muxnxn_arb
  import muxnxn_pkg::*;
#(
  parameter int M = 16,
  parameter int N = 4
) (
  input logic         muxnxn_port_clk,
  input logic         muxnxn_port_rst,
  muxnxn_arb_if.slave bus
);
  localparam int SW = $clog2(N);

  logic [N-1:0][M-1:0] in_arr;
  logic [SW-1:0]       g;
  logic                grant;
  logic                sel_ok;
  logic                accept_ok;
  logic                xfer;
  logic [M-1:0]        out_data_q;
  logic [SW-1:0]       out_chan_q;
  logic                out_valid_q;

  assign in_arr    = bus.muxnxn_port_in_data;
  assign accept_ok = !out_valid_q || bus.muxnxn_port_out_ready;
  // Out-of-range selects (non power-of-two N) never grant.
  assign sel_ok    = (int'(bus.muxnxn_port_sel) < N) &&
                     bus.muxnxn_port_in_valid[bus.muxnxn_port_sel];

`ifdef MUXNXN_ARB_RR_EN
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] rr_idx;
  logic          rr_any;
  logic          mode_rr;

  assign mode_rr = (bus.muxnxn_port_mode == MUXNXN_MODE_RR);

  muxnxn_rr_pick #(.N(N)) u_rr_pick (
    .req     (bus.muxnxn_port_in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign g     = mode_rr ? rr_idx : bus.muxnxn_port_sel;
  assign grant = mode_rr ? rr_any : sel_ok;

  // Last-granted pointer; reset to N-1 so channel 0 leads after reset.
  always_ff @(posedge muxnxn_port_clk or posedge muxnxn_port_rst) begin
    if (muxnxn_port_rst)   ptr_q <= SW'(N - 1);
    else if (xfer && mode_rr) ptr_q <= g;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.muxnxn_port_mode;
  assign g           = bus.muxnxn_port_sel;
  assign grant       = sel_ok;
`endif

  // Reset also masks ready so no producer sees a handshake while held.
  assign xfer = accept_ok && grant && !muxnxn_port_rst;
  assign bus.muxnxn_port_in_ready = xfer ? (N'(1) << g) : '0;

  // Output stage: load on transfer, drop valid on drain, hold on stall.
  always_ff @(posedge muxnxn_port_clk or posedge muxnxn_port_rst) begin
    if (muxnxn_port_rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_arr[g];
      out_chan_q  <= g;
    end else if (bus.muxnxn_port_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.muxnxn_port_out_data  = out_data_q;
  assign bus.muxnxn_port_out_chan  = out_chan_q;
  assign bus.muxnxn_port_out_valid = out_valid_q;
endmodule
